predictor_history_table: RTL and testbench

//   Branch history table feeding the prediction-check stage. Holds 2^INDEX_W
//   2-bit saturating counters indexed by branch address low bits. Issues a

---
 rtl/predictor_history_table_if.sv | 36 +++
 rtl/predictor_history_table.sv | 147 ++++++++++++++
 tb/tb_predictor_history_table.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/predictor_history_table_if.sv
// Fetch/check-stage bundle for the branch history table: lookup, update,
// clear request and the prediction/statistics returned by the table.
interface predictor_history_table_if #(
    parameter int ADDR_W = 11,
    parameter int STAT_W = 16
);
    logic              lookup_valid;
    logic [ADDR_W-1:0] lookup_addr;
    logic              predict_valid;
    logic              branch_taken;
    logic [ADDR_W-1:0] predict_addr;
    logic              update_valid;
    logic [ADDR_W-1:0] update_addr;
    logic              branch_result;
    logic              prediction_failed;
    logic              clear_req;
    logic              busy;
    logic [STAT_W-1:0] branch_count;
    logic [STAT_W-1:0] miss_count;

    modport master (
        output lookup_valid, lookup_addr,
        output update_valid, update_addr, branch_result, prediction_failed,
        output clear_req,
        input  predict_valid, branch_taken, predict_addr,
        input  busy, branch_count, miss_count
    );

    modport slave (
        input  lookup_valid, lookup_addr,
        input  update_valid, update_addr, branch_result, prediction_failed,
        input  clear_req,
        output predict_valid, branch_taken, predict_addr,
        output busy, branch_count, miss_count
    );
endinterface

// File: rtl/predictor_history_table.sv
// Branch history table of 2-bit saturating counters with registered
// prediction, same-cycle update bypass, miss statistics and sequenced clear.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | lookups predicted from the table, updates train entries
//   ST_CLEAR | one entry per cycle reset to CNT_INIT, updates dropped
module predictor_history_table #(
    parameter int         ADDR_W   = 11,
    parameter int         INDEX_W  = 4,
    parameter logic [1:0] CNT_INIT = 2'b01,
    parameter int         STAT_W   = 16
) (
    input logic                      clk,
    input logic                      reset,
    predictor_history_table_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_W;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t             state_q, state_d;
    logic [INDEX_W-1:0] ptr_q, ptr_d;
    logic               clear_we;

    logic [1:0]         table_q [ENTRIES];
    logic [1:0]         table_d [ENTRIES];

    logic               predict_valid_q, predict_valid_d;
    logic               branch_taken_q, branch_taken_d;
    logic [ADDR_W-1:0]  predict_addr_q, predict_addr_d;
    logic [STAT_W-1:0]  branch_count_q, branch_count_d;
    logic [STAT_W-1:0]  miss_count_q, miss_count_d;

    logic [INDEX_W-1:0] lk_idx;
    logic [INDEX_W-1:0] up_idx;
    logic [1:0]         up_cur;
    logic [1:0]         up_next;
    logic               upd_accept;

    assign lk_idx     = bus.lookup_addr[INDEX_W-1:0];
    assign up_idx     = bus.update_addr[INDEX_W-1:0];
    assign upd_accept = (state_q == ST_IDLE) && bus.update_valid;

    // Entries are untagged, so the upper address bits never influence the table.
    logic unused_update_addr_hi;
    assign unused_update_addr_hi = ^bus.update_addr[ADDR_W-1:INDEX_W];

    always_comb begin
        up_cur  = table_q[up_idx];
        up_next = up_cur;
        if (bus.branch_result) begin
            if (up_cur != 2'b11) up_next = up_cur + 2'd1;
        end else begin
            if (up_cur != 2'b00) up_next = up_cur - 2'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        clear_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.clear_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                clear_we = 1'b1;
                if (ptr_q == INDEX_W'(ENTRIES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // An update in the clear_req cycle still lands; the clear then overwrites it.
    always_comb begin
        table_d = table_q;
        if (upd_accept) table_d[up_idx] = up_next;
        if (clear_we)   table_d[ptr_q]  = CNT_INIT;
    end

    always_comb begin
        predict_valid_d = bus.lookup_valid;
        predict_addr_d  = predict_addr_q;
        branch_taken_d  = branch_taken_q;
        if (bus.lookup_valid) begin
            predict_addr_d = bus.lookup_addr;
            if (state_q == ST_CLEAR) begin
                branch_taken_d = 1'b0;
            end else if (upd_accept && (up_idx == lk_idx)) begin
                branch_taken_d = up_next[1];
            end else begin
                branch_taken_d = table_q[lk_idx][1];
            end
        end
    end

    always_comb begin
        branch_count_d = branch_count_q;
        miss_count_d   = miss_count_q;
        if (upd_accept) begin
            if (branch_count_q != '1) branch_count_d = branch_count_q + 1'b1;
            if (bus.prediction_failed && (miss_count_q != '1)) begin
                miss_count_d = miss_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            ptr_q           <= '0;
            predict_valid_q <= 1'b0;
            branch_taken_q  <= 1'b0;
            predict_addr_q  <= '0;
            branch_count_q  <= '0;
            miss_count_q    <= '0;
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= CNT_INIT;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            predict_valid_q <= predict_valid_d;
            branch_taken_q  <= branch_taken_d;
            predict_addr_q  <= predict_addr_d;
            branch_count_q  <= branch_count_d;
            miss_count_q    <= miss_count_d;
            table_q         <= table_d;
        end
    end

    assign bus.predict_valid = predict_valid_q;
    assign bus.branch_taken  = branch_taken_q;
    assign bus.predict_addr  = predict_addr_q;
    assign bus.busy          = (state_q == ST_CLEAR);
    assign bus.branch_count  = branch_count_q;
    assign bus.miss_count    = miss_count_q;
endmodule

// File: tb/tb_predictor_history_table.sv
// Directed bench for predictor_history_table; a second narrow-statistics
// instance exercises counter saturation in few cycles.
module tb_predictor_history_table;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   n;
    logic [15:0] bc_snap;
    logic [15:0] mc_snap;

    always #5 clk = ~clk;

    predictor_history_table_if #(.ADDR_W(11), .STAT_W(16)) bus ();
    predictor_history_table_if #(.ADDR_W(11), .STAT_W(4))  bus_s ();

    predictor_history_table #(.ADDR_W(11), .INDEX_W(4), .CNT_INIT(2'b01), .STAT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    predictor_history_table #(.ADDR_W(11), .INDEX_W(4), .CNT_INIT(2'b01), .STAT_W(4)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.lookup_valid = 0; bus.lookup_addr = '0;
        bus.update_valid = 0; bus.update_addr = '0;
        bus.branch_result = 0; bus.prediction_failed = 0; bus.clear_req = 0;
        bus_s.lookup_valid = 0; bus_s.lookup_addr = '0;
        bus_s.update_valid = 0; bus_s.update_addr = '0;
        bus_s.branch_result = 0; bus_s.prediction_failed = 0; bus_s.clear_req = 0;
    endtask

    task automatic upd(input logic [10:0] a, input logic res, input logic pf);
        bus.update_valid = 1; bus.update_addr = a;
        bus.branch_result = res; bus.prediction_failed = pf;
        step();
        bus.update_valid = 0; bus.prediction_failed = 0;
    endtask

    task automatic lookup(input logic [10:0] a, output logic taken);
        bus.lookup_valid = 1; bus.lookup_addr = a;
        step();
        bus.lookup_valid = 0;
        taken = bus.branch_taken;
    endtask

    logic t;

    initial begin
        quiet();
        reset = 1;
        step(); step();
        reset = 0;
        chk("rst_pv", bus.predict_valid, 0);
        chk("rst_taken", bus.branch_taken, 0);
        chk("rst_addr", bus.predict_addr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_bc", bus.branch_count, 0);
        chk("rst_mc", bus.miss_count, 0);

        // First lookup: weakly not-taken, echoed address, one-cycle pulse
        bus.lookup_valid = 1; bus.lookup_addr = 11'h005;
        step();
        bus.lookup_valid = 0;
        chk("lk5_pv", bus.predict_valid, 1);
        chk("lk5_taken", bus.branch_taken, 0);
        chk("lk5_addr", bus.predict_addr, 11'h005);
        step();
        chk("lk5_pv_drop", bus.predict_valid, 0);

        // Train up to saturation and read through an alias
        for (int i = 0; i < 3; i++) upd(11'h005, 1, 0);
        lookup(11'h005, t); chk("sat_hi_3", t, 1);
        for (int i = 0; i < 2; i++) upd(11'h005, 1, 0);
        lookup(11'h015, t); chk("alias_015", t, 1);
        chk("bc_5", bus.branch_count, 5);
        chk("mc_0", bus.miss_count, 0);

        // Four decrements from 11: a wrapping counter would end at 11
        for (int i = 0; i < 4; i++) upd(11'h005, 0, 0);
        lookup(11'h005, t); chk("sat_lo", t, 0);
        upd(11'h005, 1, 0);
        lookup(11'h005, t); chk("after_lo_inc", t, 0);

        // Same-cycle update/lookup on entry 3 (01 -> 10) uses the new value
        lookup(11'h003, t); chk("pre_bypass", t, 0);
        bus.update_valid = 1; bus.update_addr = 11'h003; bus.branch_result = 1;
        bus.lookup_valid = 1; bus.lookup_addr = 11'h003;
        step();
        quiet();
        chk("bypass_taken", bus.branch_taken, 1);
        chk("bypass_addr", bus.predict_addr, 11'h003);

        // Statistics from a fresh reset
        reset = 1; step(); reset = 0;
        for (int i = 0; i < 10; i++) upd(11'(i), 1, (i == 2 || i == 5 || i == 7));
        bus.prediction_failed = 1; step(); bus.prediction_failed = 0;
        chk("stat_bc10", bus.branch_count, 10);
        chk("stat_mc3", bus.miss_count, 3);

        // Narrow instance: 4-bit counters hold at all-ones
        bus_s.update_valid = 1; bus_s.prediction_failed = 1; bus_s.branch_result = 1;
        for (int i = 0; i < 15; i++) step();
        chk("sat_bc_15", bus_s.branch_count, 4'hF);
        chk("sat_mc_15", bus_s.miss_count, 4'hF);
        for (int i = 0; i < 5; i++) step();
        quiet();
        chk("sat_bc_hold", bus_s.branch_count, 4'hF);
        chk("sat_mc_hold", bus_s.miss_count, 4'hF);

        // Train all entries to 11, then clear
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 16; i++) upd(11'(i), 1, 0);
        lookup(11'h007, t); chk("trained_7", t, 1);
        chk("trained_bc", bus.branch_count, 42);
        bus.clear_req = 1; bus.update_valid = 1; bus.update_addr = 11'h002;
        bus.branch_result = 1; bus.prediction_failed = 1;
        step();
        quiet();
        chk("clr_busy", bus.busy, 1);
        chk("clr_same_cycle_bc", bus.branch_count, 43);
        chk("clr_same_cycle_mc", bus.miss_count, 4);
        bc_snap = bus.branch_count;
        mc_snap = bus.miss_count;
        n = 0;
        while (bus.busy && n < 40) begin
            bus.update_valid = 1; bus.update_addr = 11'(n % 16);
            bus.branch_result = 1; bus.prediction_failed = 1;
            bus.lookup_valid = 1; bus.lookup_addr = 11'(n % 16);
            bus.clear_req = (n == 3);
            step();
            n++;
            chk("clr_lk_pv", bus.predict_valid, 1);
            chk("clr_lk_taken", bus.branch_taken, 0);
        end
        quiet();
        chk("clr_busy_cycles", n, 16);
        chk("clr_bc_kept", bus.branch_count, bc_snap);
        chk("clr_mc_kept", bus.miss_count, mc_snap);
        step();
        chk("clr_idle", bus.busy, 0);
        for (int i = 0; i < 16; i++) begin
            lookup(11'(i), t); chk("clr_entry", t, 0);
        end
        upd(11'h009, 1, 0);
        lookup(11'h009, t); chk("clr_init_01", t, 1);

        // Reset in the middle of a clear
        upd(11'h00C, 1, 1);
        upd(11'h00C, 1, 0);
        lookup(11'h00C, t); chk("pre_rst_c", t, 1);
        bus.clear_req = 1; step(); quiet();
        for (int i = 0; i < 5; i++) step();
        chk("midclr_busy", bus.busy, 1);
        reset = 1; step(); reset = 0;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_bc", bus.branch_count, 0);
        chk("midrst_mc", bus.miss_count, 0);
        chk("midrst_pv", bus.predict_valid, 0);
        lookup(11'h00C, t); chk("midrst_entry_c", t, 0);
        upd(11'h00C, 1, 0);
        lookup(11'h00C, t); chk("midrst_idle_train", t, 1);
        chk("midrst_bc1", bus.branch_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
